// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single-port data memory between the pipeline MEM stage (port C) and the
//   loader DMA (port D). One winner per cycle drives the memory port; read data comes back
//   one cycle later on the winning port. C has priority, but a saturating starvation counter
//   and a DMA burst lock bound how long D waits. c_req & ~c_gnt is the pipeline stall.
// Ports
//   clk, rst                       clock (rising edge), asynchronous active-high reset
//   c_req/c_we/c_addr/c_wdata      CPU request, write enable, word address, write data
//   c_gnt/c_rvalid/c_rdata         CPU grant, read-valid strobe, held read data
//   d_req/d_we/d_lock/d_addr/...   DMA request, write enable, burst lock, address, data
//   d_gnt/d_rvalid/d_rdata         DMA grant, read-valid strobe, held read data
//   m_en/m_we/m_addr/m_wdata       memory port command
//   m_rdata                        memory read data, valid one cycle after a read
module dmem_arbiter #(
    parameter int unsigned ADDR_W       = 7,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [31:0]       c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [31:0]       c_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_lock,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata
);

    localparam logic [CNT_W-1:0] StarveMax = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_q, starve_d;
    logic             locked_q, locked_d;
    logic             c_rvalid_q, c_rvalid_d;
    logic             d_rvalid_q, d_rvalid_d;
    logic [31:0]      c_rdata_q, c_rdata_d;
    logic [31:0]      d_rdata_q, d_rdata_d;
    logic             c_win, d_win;

    // Winner selection; forced to no winner while reset is held so no access is issued.
    always_comb begin
        c_win = 1'b0;
        d_win = 1'b0;
        if (!rst) begin
            if (locked_q && d_req) begin
                d_win = 1'b1;
            end else if ((starve_q == StarveMax) && d_req) begin
                d_win = 1'b1;
            end else if (c_req) begin
                c_win = 1'b1;
            end else if (d_req) begin
                d_win = 1'b1;
            end
        end
    end

    // Memory port mux; all zero when idle.
    always_comb begin
        m_en    = c_win | d_win;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        if (c_win) begin
            m_we    = c_we;
            m_addr  = c_addr;
            m_wdata = c_wdata;
        end else if (d_win) begin
            m_we    = d_we;
            m_addr  = d_addr;
            m_wdata = d_wdata;
        end
    end

    always_comb begin
        // D losing to C counts up; any D win or D going idle restarts the count.
        starve_d = starve_q;
        if (!d_req || d_win) begin
            starve_d = '0;
        end else if (c_win && (starve_q != StarveMax)) begin
            starve_d = starve_q + 1'b1;
        end

        locked_d = locked_q;
        if (d_win && d_lock) begin
            locked_d = 1'b1;
        end
        if (!d_req || !d_lock) begin
            locked_d = 1'b0;
        end

        c_rvalid_d = c_win & ~c_we;
        d_rvalid_d = d_win & ~d_we;
        // Read data captured at the end of the rvalid cycle and held until the next one.
        c_rdata_d  = c_rvalid_q ? m_rdata : c_rdata_q;
        d_rdata_d  = d_rvalid_q ? m_rdata : d_rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q   <= '0;
            locked_q   <= 1'b0;
            c_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            c_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            starve_q   <= starve_d;
            locked_q   <= locked_d;
            c_rvalid_q <= c_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
            c_rdata_q  <= c_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign c_gnt    = c_win;
    assign d_gnt    = d_win;
    assign c_rvalid = c_rvalid_q;
    assign d_rvalid = d_rvalid_q;
    assign c_rdata  = c_rdata_q;
    assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_req, c_we, c_gnt, c_rvalid;
    logic [6:0]  c_addr;
    logic [31:0] c_wdata, c_rdata;
    logic        d_req, d_we, d_lock, d_gnt, d_rvalid;
    logic [6:0]  d_addr;
    logic [31:0] d_wdata, d_rdata;
    logic        m_en, m_we;
    logic [6:0]  m_addr;
    logic [31:0] m_wdata, m_rdata;

    logic [31:0] mem [128];

    int n_total = 0;
    int n_pass  = 0;

    logic [31:0] c_q[$];
    logic [31:0] d_q[$];

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(7), .STARVE_LIMIT(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    // Single-port synchronous memory, one-cycle read latency.
    initial begin
        for (int i = 0; i < 128; i++) mem[i] = '0;
        m_rdata = '0;
    end
    always @(posedge clk) begin
        if (m_en) begin
            if (m_we) mem[m_addr] <= m_wdata;
            else      m_rdata     <= mem[m_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: unexpected event at %0t", name, $time);
    endtask

    // Scoreboard: pop expected read data when rvalid shows up, then check the held register.
    logic        c_pend = 1'b0, d_pend = 1'b0;
    logic [31:0] c_pval, d_pval;
    always @(negedge clk) begin
        if (rst) begin
            c_pend = 1'b0;
            d_pend = 1'b0;
        end else begin
            if (c_pend) begin chk("c_rdata_held", c_rdata, c_pval); c_pend = 1'b0; end
            if (d_pend) begin chk("d_rdata_held", d_rdata, d_pval); d_pend = 1'b0; end
            if (c_rvalid) begin
                if (c_q.size() == 0) fail_now("c_rvalid_spurious");
                else begin
                    c_pval = c_q.pop_front();
                    chk("c_m_rdata", m_rdata, c_pval);
                    c_pend = 1'b1;
                end
            end
            if (d_rvalid) begin
                if (d_q.size() == 0) fail_now("d_rvalid_spurious");
                else begin
                    d_pval = d_q.pop_front();
                    chk("d_m_rdata", m_rdata, d_pval);
                    d_pend = 1'b1;
                end
            end
        end
    end

    typedef struct {
        logic        c_req, c_we;
        logic [6:0]  c_addr;
        logic [31:0] c_wdata;
        logic        d_req, d_we, d_lock;
        logic [6:0]  d_addr;
        logic [31:0] d_wdata;
        logic        e_c_gnt, e_d_gnt, e_m_we;
        logic [6:0]  e_m_addr;
        logic [31:0] e_m_wdata, e_rd;
    } vec_t;

    function automatic vec_t mk(input logic cr, input logic cw, input logic [6:0] ca,
                                input logic [31:0] cd, input logic dr, input logic dw,
                                input logic dl, input logic [6:0] da, input logic [31:0] dd,
                                input logic ecg, input logic edg, input logic emw,
                                input logic [6:0] ema, input logic [31:0] emd,
                                input logic [31:0] erd);
        vec_t v;
        v.c_req = cr; v.c_we = cw; v.c_addr = ca; v.c_wdata = cd;
        v.d_req = dr; v.d_we = dw; v.d_lock = dl; v.d_addr = da; v.d_wdata = dd;
        v.e_c_gnt = ecg; v.e_d_gnt = edg; v.e_m_we = emw;
        v.e_m_addr = ema; v.e_m_wdata = emd; v.e_rd = erd;
        return v;
    endfunction

    task automatic idle_in();
        c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
        d_req = 0; d_we = 0; d_lock = 0; d_addr = '0; d_wdata = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        idle_in();
        for (int i = 0; i < n; i++) next_cycle();
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = mk(1,1,20,32'hA5A5_0001, 0,0,0,0,0,          1,0,1,20,32'hA5A5_0001, 0);
        vecs[1] = mk(0,0,0,0,             1,1,0,21,32'h5A5A,   0,1,1,21,32'h5A5A, 0);
        vecs[2] = mk(1,0,20,0,            1,1,0,22,32'h77,     1,0,0,20,0, 32'hA5A5_0001);
        vecs[3] = mk(0,0,0,0,             1,0,0,21,0,          0,1,0,21,0, 32'h5A5A);
        vecs[4] = mk(0,0,0,0,             0,0,0,0,0,           0,0,0,0,0, 0);
        vecs[5] = mk(1,1,22,32'h99,       1,0,0,20,0,          1,0,1,22,32'h99, 0);
        vecs[6] = mk(0,0,0,0,             1,0,0,22,0,          0,1,0,22,0, 32'h99);
        vecs[7] = mk(1,0,21,0,            0,0,1,0,0,           1,0,0,21,0, 32'h5A5A);

        // Reset state, with both requests pending.
        idle_in();
        rst = 1'b1;
        c_req = 1; d_req = 1;
        @(negedge clk);
        chk("rst_c_gnt", c_gnt, 0);
        chk("rst_d_gnt", d_gnt, 0);
        chk("rst_m_en", m_en, 0);
        chk("rst_c_rvalid", c_rvalid, 0);
        chk("rst_d_rvalid", d_rvalid, 0);
        chk("rst_c_rdata", c_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        next_cycle();
        rst = 1'b0;
        idle_cycles(1);

        // Table: single-cycle arbitration vectors, each followed by an idle cycle.
        for (int i = 0; i < 8; i++) begin
            c_req = vecs[i].c_req; c_we = vecs[i].c_we;
            c_addr = vecs[i].c_addr; c_wdata = vecs[i].c_wdata;
            d_req = vecs[i].d_req; d_we = vecs[i].d_we; d_lock = vecs[i].d_lock;
            d_addr = vecs[i].d_addr; d_wdata = vecs[i].d_wdata;
            @(negedge clk);
            chk($sformatf("v%0d_c_gnt", i), c_gnt, vecs[i].e_c_gnt);
            chk($sformatf("v%0d_d_gnt", i), d_gnt, vecs[i].e_d_gnt);
            chk($sformatf("v%0d_m_en", i), m_en, vecs[i].e_c_gnt | vecs[i].e_d_gnt);
            chk($sformatf("v%0d_m_we", i), m_we, vecs[i].e_m_we);
            chk($sformatf("v%0d_m_addr", i), m_addr, vecs[i].e_m_addr);
            chk($sformatf("v%0d_m_wdata", i), m_wdata, vecs[i].e_m_wdata);
            if (vecs[i].e_c_gnt && !vecs[i].c_we) c_q.push_back(vecs[i].e_rd);
            if (vecs[i].e_d_gnt && !vecs[i].d_we) d_q.push_back(vecs[i].e_rd);
            next_cycle();
            idle_cycles(1);
        end
        idle_cycles(1);

        // 1: C write then C read of address 5.
        c_req = 1; c_we = 1; c_addr = 5; c_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("t1_c_gnt", c_gnt, 1);
        chk("t1_m_we", m_we, 1);
        chk("t1_m_addr", m_addr, 5);
        next_cycle();
        c_we = 0; c_wdata = 0;
        @(negedge clk);
        chk("t1_rd_gnt", c_gnt, 1);
        c_q.push_back(32'hDEAD_BEEF);
        next_cycle();
        idle_in();
        @(negedge clk);
        chk("t1_c_rvalid", c_rvalid, 1);
        next_cycle();
        idle_cycles(1);

        // 2: C and D (read addr 5) both held; D forced through on the 5th cycle.
        c_req = 1; c_we = 1; c_addr = 30; c_wdata = 32'h1;
        d_req = 1; d_we = 0; d_addr = 5;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            chk($sformatf("t2_c_gnt_%0d", cyc), c_gnt, (cyc == 5) ? 0 : 1);
            chk($sformatf("t2_d_gnt_%0d", cyc), d_gnt, (cyc == 5) ? 1 : 0);
            if (cyc == 5) d_q.push_back(32'hDEAD_BEEF);
            if (cyc == 6) chk("t2_d_rvalid", d_rvalid, 1);
            next_cycle();
        end
        idle_cycles(2);

        // 3: locked D write burst to 0..2 while C keeps requesting.
        c_req = 1; c_we = 1; c_addr = 31; c_wdata = 32'h2;
        d_req = 1; d_we = 1; d_lock = 1; d_addr = 0; d_wdata = 32'h100;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            if (cyc == 8) begin d_req = 0; d_lock = 0; end
            @(negedge clk);
            chk($sformatf("t3_c_gnt_%0d", cyc), c_gnt, (cyc >= 5 && cyc <= 7) ? 0 : 1);
            chk($sformatf("t3_d_gnt_%0d", cyc), d_gnt, (cyc >= 5 && cyc <= 7) ? 1 : 0);
            next_cycle();
            if (cyc >= 5 && cyc <= 6) begin
                d_addr = d_addr + 7'd1;
                d_wdata = d_wdata + 32'h1;
            end
        end
        idle_cycles(2);

        // 4: C reads addr 9 while D writes 0x11 there; D wins once starved, C then sees it.
        c_req = 1; c_we = 0; c_addr = 9;
        d_req = 1; d_we = 1; d_addr = 9; d_wdata = 32'h11;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            if (cyc == 6) d_req = 0;
            @(negedge clk);
            chk($sformatf("t4_c_gnt_%0d", cyc), c_gnt, (cyc == 5) ? 0 : 1);
            if (cyc == 5) begin
                chk("t4_d_gnt", d_gnt, 1);
                chk("t4_m_we", m_we, 1);
                chk("t4_m_addr", m_addr, 9);
            end
            if (cyc != 5) c_q.push_back((cyc == 6) ? 32'h11 : 32'h0);
            next_cycle();
        end
        idle_cycles(3);

        // 6: idle for 10 cycles; read data registers hold their last values.
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            chk($sformatf("t6_m_en_%0d", cyc), m_en, 0);
            chk($sformatf("t6_rv_%0d", cyc), {c_rvalid, d_rvalid}, 0);
            next_cycle();
        end
        chk("t6_c_rdata", c_rdata, 32'h11);
        chk("t6_d_rdata", d_rdata, 32'hDEAD_BEEF);

        // 5: reset in the cycle after a granted C read drops the pending rvalid.
        c_req = 1; c_we = 0; c_addr = 5;
        @(negedge clk);
        chk("t5_c_gnt", c_gnt, 1);
        next_cycle();
        rst = 1'b1;
        for (int cyc = 0; cyc < 2; cyc++) begin
            @(negedge clk);
            chk($sformatf("t5_c_rvalid_%0d", cyc), c_rvalid, 0);
            chk($sformatf("t5_c_rdata_%0d", cyc), c_rdata, 0);
            chk($sformatf("t5_m_en_%0d", cyc), m_en, 0);
            chk($sformatf("t5_c_gnt_rst_%0d", cyc), c_gnt, 0);
            next_cycle();
        end
        rst = 1'b0;
        idle_in();
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge clk);
            chk($sformatf("t5_post_gnt_%0d", cyc), {c_gnt, d_gnt, m_en}, 0);
            chk($sformatf("t5_post_rv_%0d", cyc), {c_rvalid, d_rvalid}, 0);
            next_cycle();
        end

        chk("c_queue_drained", c_q.size(), 0);
        chk("d_queue_drained", d_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
